// File: rtl/alu_pkg.sv
// Definitions shared by the decode/issue stage and the 16-bit ALU: function codes,
// instruction field layout and datapath width.
package alu_pkg;

  localparam int DW    = 16;
  localparam int NREG  = 8;
  localparam int IMM_W = 6;
  localparam int RW    = 3;

  typedef enum logic [2:0] {
    FN_PASSB = 3'b000,
    FN_ADD   = 3'b001,
    FN_SUB   = 3'b010,
    FN_AND   = 3'b011,
    FN_OR    = 3'b100,
    FN_SHL1  = 3'b101,
    FN_SHR1  = 3'b110,
    FN_NOP   = 3'b111
  } alu_func_e;

  localparam int FUNC_HI = 15;
  localparam int FUNC_LO = 13;
  localparam int IMM_BIT = 12;
  localparam int RD_HI   = 11;
  localparam int RD_LO   = 9;
  localparam int RA_HI   = 8;
  localparam int RA_LO   = 6;
  localparam int RB_HI   = 5;
  localparam int RB_LO   = 3;
  localparam int IMM6_HI = 5;
  localparam int IMM6_LO = 0;

  typedef struct packed {
    alu_func_e           func;
    logic                imm;
    logic [RW-1:0]       rd;
    logic [RW-1:0]       ra;
    logic [RW-1:0]       rb;
    logic [IMM_W-1:0]    imm6;
  } inst_t;

  function automatic inst_t decode_inst(input logic [15:0] w);
    inst_t d;
    d.func = alu_func_e'(w[FUNC_HI:FUNC_LO]);
    d.imm  = w[IMM_BIT];
    d.rd   = w[RD_HI:RD_LO];
    d.ra   = w[RA_HI:RA_LO];
    d.rb   = w[RB_HI:RB_LO];
    d.imm6 = w[IMM6_HI:IMM6_LO];
    return d;
  endfunction

  // Pass-B and NOP leave operand A untouched.
  function automatic logic reads_ra(input alu_func_e f);
    return (f != FN_PASSB) && (f != FN_NOP);
  endfunction

  // Shifts are unary and an immediate replaces rb entirely.
  function automatic logic reads_rb(input alu_func_e f, input logic imm);
    return !imm && (f != FN_SHL1) && (f != FN_SHR1) && (f != FN_NOP);
  endfunction

endpackage

// File: rtl/regfile_8x16.sv
// Register file with one write port, two combinational operand reads and a debug read.
module regfile_8x16 #(
  parameter int DW   = alu_pkg::DW,
  parameter int NREG = alu_pkg::NREG,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a  = mem[raddr_a];
  assign rdata_b  = mem[raddr_b];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage in front of the ALU: operand fetch with forwarding from the
// writeback slot, a one-cycle stall on results still inside the ALU, and writeback.
module decode_issue #(
  parameter int DW    = alu_pkg::DW,
  parameter int NREG  = alu_pkg::NREG,
  parameter int IMM_W = alu_pkg::IMM_W,
  parameter int AW    = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   inst,
  input  logic          inst_valid,
  output logic          inst_ready,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_func,
  output logic          en_out,
  input  logic [DW-1:0] alu_result,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  import alu_pkg::*;

  inst_t         dec;
  logic          use_a, use_b;
  logic          hz_a, hz_b, fw_a, fw_b;
  logic          stall, fire, issue;
  logic [DW-1:0] rf_a, rf_b;
  logic [DW-1:0] op_a_p0, op_b_p0;
  logic [DW-1:0] imm_ext;

  logic          s1_vld_p1;
  logic [AW-1:0] s1_rd_p1;
  logic          s2_vld_p2;
  logic [AW-1:0] s2_rd_p2;

  assign dec     = decode_inst(inst);
  assign use_a   = reads_ra(dec.func);
  assign use_b   = reads_rb(dec.func, dec.imm);
  assign imm_ext = {{(DW-IMM_W){1'b0}}, dec.imm6[IMM_W-1:0]};

  // A producer still in s1 has no result yet; one in s2 has it on alu_result.
  assign hz_a = use_a && s1_vld_p1 && (s1_rd_p1 == dec.ra);
  assign hz_b = use_b && s1_vld_p1 && (s1_rd_p1 == dec.rb);
  assign fw_a = use_a && s2_vld_p2 && (s2_rd_p2 == dec.ra);
  assign fw_b = use_b && s2_vld_p2 && (s2_rd_p2 == dec.rb);

  assign stall      = inst_valid && (hz_a || hz_b);
  assign inst_ready = !stall;
  assign fire       = inst_valid && inst_ready;
  assign issue      = fire && (dec.func != FN_NOP);

  regfile_8x16 #(
    .DW   (DW),
    .NREG (NREG),
    .AW   (AW)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .we       (s2_vld_p2),
    .waddr    (s2_rd_p2),
    .wdata    (alu_result),
    .raddr_a  (dec.ra),
    .rdata_a  (rf_a),
    .raddr_b  (dec.rb),
    .rdata_b  (rf_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_comb begin
    op_a_p0 = '0;
    if (use_a) op_a_p0 = fw_a ? alu_result : rf_a;
  end

  always_comb begin
    op_b_p0 = '0;
    if (dec.imm)    op_b_p0 = imm_ext;
    else if (use_b) op_b_p0 = fw_b ? alu_result : rf_b;
  end

  // p0 -> p1: register ALU inputs and open the s1 token
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_func  <= '0;
      en_out    <= 1'b0;
      s1_vld_p1 <= 1'b0;
      s1_rd_p1  <= '0;
    end else begin
      en_out    <= issue;
      s1_vld_p1 <= issue;
      if (issue) begin
        alu_a    <= op_a_p0;
        alu_b    <= op_b_p0;
        alu_func <= dec.func;
        s1_rd_p1 <= dec.rd;
      end
    end
  end

  // p1 -> p2: token waits in s2 while the ALU presents its result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld_p2 <= 1'b0;
      s2_rd_p2  <= '0;
    end else begin
      s2_vld_p2 <= s1_vld_p1;
      s2_rd_p2  <= s1_rd_p1;
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue with a behavioural registered ALU closing the writeback loop.
module tb_decode_issue;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_func;
  logic        en_out;
  logic [15:0] alu_result;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decode_issue dut (
    .clk        (clk),
    .rst        (rst),
    .inst       (inst),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_func   (alu_func),
    .en_out     (en_out),
    .alu_result (alu_result),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  function automatic logic [15:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] f);
    case (f)
      3'b000:  return b;
      3'b001:  return a + b;
      3'b010:  return a - b;
      3'b011:  return a & b;
      3'b100:  return a | b;
      3'b101:  return a << 1;
      3'b110:  return a >> 1;
      default: return 16'h0000;
    endcase
  endfunction

  // Registered ALU: result appears the cycle after en_out.
  always @(posedge clk or posedge rst) begin
    if (rst) alu_result <= 16'h0000;
    else if (en_out) alu_result <= alu_ref(alu_a, alu_b, alu_func);
  end

  function automatic logic [15:0] enc(input logic [2:0] f, input logic im, input logic [2:0] rd,
                                      input logic [2:0] ra, input logic [5:0] lo);
    return {f, im, rd, ra, lo};
  endfunction

  function automatic logic [15:0] encr(input logic [2:0] f, input logic [2:0] rd,
                                       input logic [2:0] ra, input logic [2:0] rb);
    return {f, 1'b0, rd, ra, rb, 3'b000};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_rf(input string nm, input logic [2:0] r, input logic [15:0] exp);
    dbg_addr = r;
    #1;
    check(nm, {16'h0, dbg_data}, {16'h0, exp});
  endtask

  typedef struct {
    string       name;
    logic [15:0] inst;
    logic        exp_en;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic [2:0]  rd;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs[10];

  logic [15:0] seq_inst[4];
  logic        seq_en[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"ldi r2=5",      16'h1405,                 1'b1, 16'h0000, 16'h0005, 3'd2, 16'h0005};
    vecs[1] = '{"ldi r3=9",      enc(3'd0,1'b1,3'd3,3'd0,6'd9),  1'b1, 16'h0000, 16'h0009, 3'd3, 16'h0009};
    vecs[2] = '{"add r4=r2+r3",  encr(3'd1,3'd4,3'd2,3'd3),      1'b1, 16'h0005, 16'h0009, 3'd4, 16'h000E};
    vecs[3] = '{"sub r7=r1-1",   enc(3'd2,1'b1,3'd7,3'd1,6'd1),  1'b1, 16'h0000, 16'h0001, 3'd7, 16'hFFFF};
    vecs[4] = '{"shr r6=r7>>1",  encr(3'd6,3'd6,3'd7,3'd0),      1'b1, 16'hFFFF, 16'h0000, 3'd6, 16'h7FFF};
    vecs[5] = '{"ldi r1=63",     enc(3'd0,1'b1,3'd1,3'd0,6'd63), 1'b1, 16'h0000, 16'h003F, 3'd1, 16'h003F};
    vecs[6] = '{"and r5=r6&r1",  encr(3'd3,3'd5,3'd6,3'd1),      1'b1, 16'h7FFF, 16'h003F, 3'd5, 16'h003F};
    vecs[7] = '{"or r0=r2|r3",   encr(3'd4,3'd0,3'd2,3'd3),      1'b1, 16'h0005, 16'h0009, 3'd0, 16'h000D};
    vecs[8] = '{"nop rd=2",      encr(3'd7,3'd2,3'd0,3'd0),      1'b0, 16'h0000, 16'h0000, 3'd2, 16'h0005};
    vecs[9] = '{"shl r6=r2<<1",  encr(3'd5,3'd6,3'd2,3'd7),      1'b1, 16'h0005, 16'h0000, 3'd6, 16'h000A};

    rst = 1'b1; inst = 16'h0; inst_valid = 1'b0; dbg_addr = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst en_out", {31'h0, en_out}, 32'h0);
    check("rst alu_a", {16'h0, alu_a}, 32'h0);
    check("rst alu_b", {16'h0, alu_b}, 32'h0);
    check("rst alu_func", {29'h0, alu_func}, 32'h0);
    check("rst ready", {31'h0, inst_ready}, 32'h1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset while add r1 is still in flight: writeback must be dropped.
    inst = enc(3'd1, 1'b1, 3'd1, 3'd0, 6'd3); inst_valid = 1'b1;
    @(posedge clk); #1;
    inst_valid = 1'b0;
    check("t1 en before rst", {31'h0, en_out}, 32'h1);
    check("t1 alu_b before rst", {16'h0, alu_b}, 32'h3);
    rst = 1'b1; #1;
    check("t1 rst en_out", {31'h0, en_out}, 32'h0);
    check("t1 rst alu_b", {16'h0, alu_b}, 32'h0);
    check("t1 rst alu_func", {29'h0, alu_func}, 32'h0);
    repeat (2) @(posedge clk); #1;
    check("t1 rst held en_out", {31'h0, en_out}, 32'h0);
    check("t1 rst held alu_a", {16'h0, alu_a}, 32'h0);
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_rf("t1 r1 dropped", 3'd1, 16'h0000);

    // Isolated single instructions.
    for (int i = 0; i < 10; i++) begin
      inst = vecs[i].inst; inst_valid = 1'b1;
      #1;
      check({vecs[i].name, " ready"}, {31'h0, inst_ready}, 32'h1);
      @(posedge clk); #1;
      inst_valid = 1'b0;
      check({vecs[i].name, " en_out"}, {31'h0, en_out}, {31'h0, vecs[i].exp_en});
      if (vecs[i].exp_en) begin
        check({vecs[i].name, " alu_a"}, {16'h0, alu_a}, {16'h0, vecs[i].exp_a});
        check({vecs[i].name, " alu_b"}, {16'h0, alu_b}, {16'h0, vecs[i].exp_b});
        check({vecs[i].name, " alu_func"}, {29'h0, alu_func}, {29'h0, vecs[i].inst[15:13]});
      end
      repeat (2) @(posedge clk); #1;
      check_rf({vecs[i].name, " rf"}, vecs[i].rd, vecs[i].exp_rd);
    end

    // Dependent pair: add r4=r2+r3 then sub r5=r4-r2, one bubble then forward.
    inst = encr(3'd1, 3'd4, 3'd2, 3'd3); inst_valid = 1'b1;
    #1;
    check("t3 add ready", {31'h0, inst_ready}, 32'h1);
    @(posedge clk); #1;
    inst = encr(3'd2, 3'd5, 3'd4, 3'd2);
    #1;
    check("t3 stall ready", {31'h0, inst_ready}, 32'h0);
    check("t3 add en_out", {31'h0, en_out}, 32'h1);
    check("t3 add alu_a", {16'h0, alu_a}, 32'h5);
    check("t3 add alu_b", {16'h0, alu_b}, 32'h9);
    @(posedge clk); #1;
    check("t3 release ready", {31'h0, inst_ready}, 32'h1);
    check("t3 bubble en_out", {31'h0, en_out}, 32'h0);
    @(posedge clk); #1;
    inst_valid = 1'b0;
    check("t3 sub en_out", {31'h0, en_out}, 32'h1);
    check("t3 sub fwd alu_a", {16'h0, alu_a}, 32'hE);
    check("t3 sub alu_b", {16'h0, alu_b}, 32'h5);
    check("t3 sub alu_func", {29'h0, alu_func}, 32'h2);
    check_rf("t3 r4", 3'd4, 16'h000E);
    repeat (2) @(posedge clk); #1;
    check_rf("t3 r5", 3'd5, 16'h0009);

    // Full-rate independent stream on disjoint registers.
    seq_inst[0] = enc(3'd0, 1'b1, 3'd0, 3'd0, 6'h11);
    seq_inst[1] = enc(3'd1, 1'b1, 3'd1, 3'd5, 6'd2);
    seq_inst[2] = enc(3'd2, 1'b1, 3'd6, 3'd4, 6'd4);
    seq_inst[3] = encr(3'd5, 3'd7, 3'd3, 3'd0);
    for (int i = 0; i < 4; i++) begin
      inst = seq_inst[i]; inst_valid = 1'b1;
      #1;
      check($sformatf("t4 ready %0d", i), {31'h0, inst_ready}, 32'h1);
      @(posedge clk); #1;
      check($sformatf("t4 en_out %0d", i), {31'h0, en_out}, 32'h1);
    end
    inst_valid = 1'b0;
    @(posedge clk); #1;
    check("t4 en_out end", {31'h0, en_out}, 32'h0);
    @(posedge clk); #1;
    check_rf("t4 r0", 3'd0, 16'h0011);
    check_rf("t4 r1", 3'd1, 16'h000B);
    check_rf("t4 r6", 3'd6, 16'h000A);
    check_rf("t4 r7", 3'd7, 16'h0012);

    // Unused operand fields and NOP destinations never stall.
    seq_inst[0] = enc(3'd0, 1'b1, 3'd4, 3'd0, 6'd7);
    seq_inst[1] = encr(3'd5, 3'd6, 3'd2, 3'd4);
    seq_inst[2] = encr(3'd7, 3'd1, 3'd0, 3'd0);
    seq_inst[3] = enc(3'd4, 1'b1, 3'd5, 3'd1, 6'd0);
    seq_en[0] = 1'b1; seq_en[1] = 1'b1; seq_en[2] = 1'b0; seq_en[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inst = seq_inst[i]; inst_valid = 1'b1;
      #1;
      check($sformatf("t5 ready %0d", i), {31'h0, inst_ready}, 32'h1);
      @(posedge clk); #1;
      check($sformatf("t5 en_out %0d", i), {31'h0, en_out}, {31'h0, seq_en[i]});
    end
    inst_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    check_rf("t5 r4", 3'd4, 16'h0007);
    check_rf("t5 r6 shl", 3'd6, 16'h000A);
    check_rf("t5 r5", 3'd5, 16'h000B);
    check_rf("t5 r1 nop", 3'd1, 16'h000B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_issue.md
Name: decode_issue

Overview:
- Decode/issue stage directly upstream of the 16-bit ALU.
- Accepts 16-bit instructions over a valid/ready handshake and holds the 8x16 register file.
- Drives the ALU operand, function and enable inputs, and writes the ALU result back two cycles after issue.
- Detects read-after-write hazards, forwarding where the result is available and stalling where it is not.

Parameters:
- DW, 16, datapath width (matches ALU operands).
- NREG, 8, register count (3-bit register fields).
- IMM_W, 6, immediate field width, zero-extended to DW.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- inst  in  16  instruction word: [15:13] func, [12] imm, [11:9] rd, [8:6] ra, [5:3] rb, [5:0] imm6.
- inst_valid  in  1  instruction present.
- inst_ready  out  1  stage can accept; combinational, = !stall.
- alu_a  out  DW  operand A to ALU (registered).
- alu_b  out  DW  operand B to ALU (registered).
- alu_func  out  3  ALU function code (registered).
- en_out  out  1  one-cycle ALU enable pulse (registered).
- alu_result  in  DW  ALU output, valid the cycle after en_out.
- dbg_addr  in  3  debug register select.
- dbg_data  out  DW  combinational read of rf[dbg_addr].

Behaviour:
- Reset (asynchronous, active-high): rf all 0; alu_a, alu_b, alu_func = 0; en_out = 0; pipeline tokens s1, s2 cleared. Any pending writeback is dropped.
- Function codes (fixed, shared with ALU):
  - 000 pass B; 001 add; 010 sub; 011 and; 100 or; 101 shl1; 110 shr1.
  - 111 is a NOP: accepted, no en_out, no writeback.
- Operand use:
  - ra is read for funcs 001-110 (not for 000).
  - rb is read only when imm = 0 and func is not 101 or 110.
  - imm = 1: alu_b = zero-extended imm6.
  - When an operand is unused, its output is 0.
- Fire: inst_valid & inst_ready at a clk edge E0.
  - After E0: operands, func and en_out = 1 registered; token s1 = {rd}.
  - After E1: token moves to s2 while the ALU holds the result on alu_result.
  - At E2: rf[rd of s2] <= alu_result; s2 clears unless refilled.
- en_out is high for exactly one cycle per fired non-NOP instruction.
- Back-to-back independent instructions issue every cycle.
- Operand source priority for a used register r:
  1. If s1 is valid and s1.rd == r: stall (inst_ready = 0). Nothing is registered; en_out = 0 next cycle.
  2. Else if s2 is valid and s2.rd == r: forward alu_result.
  3. Else: read rf[r].
- Dependent back-to-back pair costs exactly one bubble.
- Stall releases one cycle later because s1 has advanced to s2.
- A NOP never sets s1/s2; unused-operand register fields never cause a stall.
- The rf write at E2 and a forward in the same cycle agree (forward path wins); the write is always performed.
- inst_valid low: en_out = 0 next cycle; the tokens still drain.
- alu_a, alu_b and alu_func hold their last values when en_out = 0.
- Arithmetic is performed only in the ALU; this stage does no arithmetic and does no width checking beyond zero-extension.
- dbg_data reflects register-file contents only, not forwarded values.

Decomposition:
- Shared package (alu_pkg) holds:
  - the 3-bit function code constants, also used by the ALU;
  - instruction field bit positions;
  - DW.
- One natural sub-module: regfile_8x16.
  - Asynchronous reset to 0.
  - 1 write port; 2 combinational read ports plus the debug read port.
- Hazard/forward logic and pipeline tokens stay in decode_issue.

Test Plan:
1. Reset mid-flight: issue add r1, then assert rst before writeback -> rf[1] stays 0; en_out = 0 and all outputs 0 while rst is high.
2. Immediate load: pass-B imm r2 = 5 (inst 0x1405), then pass-B imm r3 = 9 -> en_out pulses two consecutive cycles; dbg r2 = 5 and r3 = 9 two cycles after each fire.
3. Stall + forward: r2 = 5, r3 = 9 loaded, then back-to-back add r4 = r2 + r3, then sub r5 = r4 - r2:
   - inst_ready is low for exactly one cycle;
   - the sub then issues with alu_a forwarded = 14 (0x000E) and alu_b = 5;
   - final rf: r4 = 14, r5 = 9.
4. Full-rate independent stream: four instructions on disjoint registers with inst_valid held high -> inst_ready stays 1; en_out high four consecutive cycles; all four results written in order.
5. NOP and unused-operand cases:
   - func 111 whose rd matches the next instruction's ra -> no stall, no en_out, no write.
   - Shift r6 = shl(r2) with rb equal to the rd of the preceding instruction -> no stall; result 10 for r2 = 5.
6. Boundary arithmetic: r1 = 0, then sub r7 = r1 - imm 1 -> r7 = 0xFFFF. Shr1 of 0xFFFF -> 0x7FFF. Imm6 = 63 -> alu_b = 0x003F.
